mem_controller: RTL and testbench

Arbitrates the instruction-fetch port and the data-memory port onto the single 256K×16 asynchronous SRAM. Each 32-bit word is split into two 16-bit halves, so one access takes two SRAM cycles. The block drives a pipeline-wide stall while an access is in flight. It sits directly upstream of the fetch stage and supplies the instruction word that stage registers into the decode pipeline register.

---
 rtl/mem_controller.sv | 187 ++++++++++++++++++
 tb/tb_mem_controller.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_controller.sv
// Two-cycle-per-word controller sharing one 256Kx16 async SRAM between fetch and data ports.
// Optional MC_BYTE_WRITE_EN adds per-byte write enables on the data port.
module mem_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_mc_en,
    input  logic [17:0] if_mc_addr,
    output logic [31:0] mc_if_data,
    input  logic        mem_mc_en,
    input  logic        mem_mc_rw,
    input  logic [17:0] mem_mc_addr,
    input  logic [31:0] mem_mc_wdata,
`ifdef MC_BYTE_WRITE_EN
    input  logic [3:0]  mem_mc_be,
`endif
    output logic [31:0] mc_mem_data,
    output logic        mc_stall,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_data_out,
    input  logic [15:0] sram_data_in,
    output logic        sram_data_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        D_HI = 3'd1,
        D_LO = 3'd2,
        I_HI = 3'd3,
        I_LO = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] fetch_addr_q;
    logic [15:0] data_addr_q;
    logic        rw_q;
    logic [31:0] wdata_q;
    logic        fetch_pend_q;
    logic [3:0]  be_q;
    logic [15:0] hi_q;
    logic [17:0] addr_q;
    logic [15:0] dout_q;

    logic        in_data;
    logic        in_inst;
    logic        half_lo;
    logic        data_write;
    logic        data_read;
    logic        start;

    // Byte-address bits [1:0] never reach the SRAM; word alignment is implied.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{if_mc_addr[1:0], mem_mc_addr[1:0]};

    assign start      = (state == IDLE) && (mem_mc_en || if_mc_en);
    assign in_data    = (state == D_HI) || (state == D_LO);
    assign in_inst    = (state == I_HI) || (state == I_LO);
    assign half_lo    = (state == D_LO) || (state == I_LO);
    assign data_write = in_data && rw_q;
    assign data_read  = in_data && !rw_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A pending fetch latched alongside a data request is chained after D_LO,
    // so a combined transaction completes with only one DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mem_mc_en) begin
                    state_next = D_HI;
                end else if (if_mc_en) begin
                    state_next = I_HI;
                end
            end
            D_HI:    state_next = D_LO;
            D_LO:    state_next = fetch_pend_q ? I_HI : DONE;
            I_HI:    state_next = I_LO;
            I_LO:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes decode straight from state so an asynchronous reset releases them at once.
    always_comb begin
        mc_stall      = 1'b0;
        sram_addr     = addr_q;
        sram_data_out = dout_q;
        sram_data_oe  = 1'b0;
        sram_ce_n     = 1'b1;
        sram_oe_n     = 1'b1;
        sram_we_n     = 1'b1;
        sram_ub_n     = 1'b1;
        sram_lb_n     = 1'b1;

        case (state)
            IDLE:    mc_stall = if_mc_en || mem_mc_en;
            DONE:    mc_stall = 1'b0;
            default: mc_stall = 1'b1;
        endcase

        if (in_data || in_inst) begin
            sram_addr = {1'b0, (in_data ? data_addr_q : fetch_addr_q), half_lo};
            sram_ce_n = 1'b0;
            sram_ub_n = 1'b0;
            sram_lb_n = 1'b0;
        end

        if (data_read || in_inst) begin
            sram_oe_n = 1'b0;
        end

        if (data_write) begin
            sram_we_n     = 1'b0;
            sram_data_oe  = 1'b1;
            sram_data_out = half_lo ? wdata_q[15:0] : wdata_q[31:16];
            sram_ub_n     = half_lo ? ~be_q[1] : ~be_q[3];
            sram_lb_n     = half_lo ? ~be_q[0] : ~be_q[2];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_addr_q <= 16'd0;
            data_addr_q  <= 16'd0;
            rw_q         <= 1'b0;
            wdata_q      <= 32'd0;
            fetch_pend_q <= 1'b0;
            be_q         <= 4'hF;
        end else if (start) begin
            fetch_addr_q <= if_mc_addr[17:2];
            data_addr_q  <= mem_mc_addr[17:2];
            rw_q         <= mem_mc_rw;
            wdata_q      <= mem_mc_wdata;
            fetch_pend_q <= if_mc_en;
`ifdef MC_BYTE_WRITE_EN
            be_q         <= mem_mc_be;
`else
            be_q         <= 4'hF;
`endif
        end
    end

    // Upper half is parked in hi_q; output registers only load on a completed LO cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_q        <= 16'd0;
            mc_if_data  <= 32'd0;
            mc_mem_data <= 32'd0;
        end else begin
            if ((state == D_HI && !rw_q) || state == I_HI) begin
                hi_q <= sram_data_in;
            end
            if (state == D_LO && !rw_q) begin
                mc_mem_data <= {hi_q, sram_data_in};
            end
            if (state == I_LO) begin
                mc_if_data <= {hi_q, sram_data_in};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= 18'd0;
            dout_q <= 16'd0;
        end else begin
            addr_q <= sram_addr;
            dout_q <= sram_data_out;
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: behavioural SRAM, directed fetch/data/reset vectors.
module tb_mem_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_mc_en = 1'b0;
    logic [17:0] if_mc_addr = 18'd0;
    logic [31:0] mc_if_data;
    logic        mem_mc_en = 1'b0;
    logic        mem_mc_rw = 1'b0;
    logic [17:0] mem_mc_addr = 18'd0;
    logic [31:0] mem_mc_wdata = 32'd0;
    logic [3:0]  mem_mc_be = 4'hF;
    logic [31:0] mc_mem_data;
    logic        mc_stall;
    logic [17:0] sram_addr;
    logic [15:0] sram_data_out;
    logic [15:0] sram_data_in;
    logic        sram_data_oe;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    logic [15:0] sram_mem [0:262143];

    mem_controller dut (
        .clock(clock),
        .reset(reset),
        .if_mc_en(if_mc_en),
        .if_mc_addr(if_mc_addr),
        .mc_if_data(mc_if_data),
        .mem_mc_en(mem_mc_en),
        .mem_mc_rw(mem_mc_rw),
        .mem_mc_addr(mem_mc_addr),
        .mem_mc_wdata(mem_mc_wdata),
`ifdef MC_BYTE_WRITE_EN
        .mem_mc_be(mem_mc_be),
`endif
        .mc_mem_data(mc_mem_data),
        .mc_stall(mc_stall),
        .sram_addr(sram_addr),
        .sram_data_out(sram_data_out),
        .sram_data_in(sram_data_in),
        .sram_data_oe(sram_data_oe),
        .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n)
    );

    always #5 clock = ~clock;

    assign sram_data_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'h0000;

    always @(negedge clock) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) sram_mem[sram_addr][15:8] <= sram_data_out[15:8];
            if (!sram_lb_n) sram_mem[sram_addr][7:0]  <= sram_data_out[7:0];
        end
    end

    typedef struct {
        int          id;
        logic [31:0] exp_if;
        logic [31:0] exp_mem;
        int          exp_len;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   stall_cnt = 0;
    int   we_cnt = 0;
    int   oe_cnt = 0;
    logic [31:0] m_if = 32'd0;
    logic [31:0] m_mem = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input int len);
        exp_t e;
        e.id = id;
        e.exp_if = m_if;
        e.exp_mem = m_mem;
        e.exp_len = len;
        sb.push_back(e);
    endtask

    // Monitor: a falling stall marks the DONE cycle of a transaction.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            stall_cnt = 0;
        end else if (mc_stall) begin
            stall_cnt++;
        end else if (stall_cnt != 0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got stall_len %0d expected no transaction", stall_cnt);
            end else begin
                e = sb.pop_front();
                check($sformatf("txn%0d_if_data", e.id), mc_if_data, e.exp_if);
                check($sformatf("txn%0d_mem_data", e.id), mc_mem_data, e.exp_mem);
                check($sformatf("txn%0d_stall_len", e.id), 32'(stall_cnt), 32'(e.exp_len));
            end
            stall_cnt = 0;
        end
    end

    always @(negedge clock) begin
        if (!sram_we_n) we_cnt++;
        if (sram_data_oe) oe_cnt++;
    end

    task automatic issue(input logic f, input logic [17:0] fa, input logic d, input logic rw,
                         input logic [17:0] da, input logic [31:0] wd, input logic [3:0] be,
                         input int hold);
        @(posedge clock);
        #1;
        if_mc_en = f;
        if_mc_addr = fa;
        mem_mc_en = d;
        mem_mc_rw = rw;
        mem_mc_addr = da;
        mem_mc_wdata = wd;
        mem_mc_be = be;
        repeat (hold) @(posedge clock);
        #1;
        if_mc_en = 1'b0;
        mem_mc_en = 1'b0;
    endtask

    initial begin
        logic [17:0] exp_a [4];
        exp_a[0] = 18'h00010;
        exp_a[1] = 18'h00011;
        exp_a[2] = 18'h00000;
        exp_a[3] = 18'h00001;

        sram_mem[18'h200] = 16'h1234;
        sram_mem[18'h201] = 16'hABCD;
        sram_mem[18'h010] = 16'h5566;
        sram_mem[18'h011] = 16'h7788;
        sram_mem[18'h000] = 16'h0102;
        sram_mem[18'h001] = 16'h0304;
        sram_mem[18'h008] = 16'h0000;
        sram_mem[18'h009] = 16'h0000;
        sram_mem[18'h00C] = 16'hFFFF;
        sram_mem[18'h00D] = 16'hFFFF;

        #2;
        check("rst_if_data", mc_if_data, 32'd0);
        check("rst_mem_data", mc_mem_data, 32'd0);
        check("rst_stall", {31'd0, mc_stall}, 32'd0);
        check("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check("rst_data_oe", {31'd0, sram_data_oe}, 32'd0);
        check("rst_data_out", {16'd0, sram_data_out}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Fetch from byte address 0x400 -> halfwords 0x200/0x201.
        m_if = 32'h1234ABCD;
        push(1, 3);
        issue(1'b1, 18'h00400, 1'b0, 1'b0, 18'd0, 32'd0, 4'hF, 1);
        repeat (3) @(posedge clock);

        // Full-word write; data output must not move.
        we_cnt = 0;
        oe_cnt = 0;
        push(2, 3);
        issue(1'b0, 18'd0, 1'b1, 1'b1, 18'h00010, 32'hDEADBEEF, 4'hF, 1);
        repeat (3) @(posedge clock);
        #1;
        check("wr_hi_half", {16'd0, sram_mem[18'h008]}, 32'h0000DEAD);
        check("wr_lo_half", {16'd0, sram_mem[18'h009]}, 32'h0000BEEF);
        check("wr_we_cycles", 32'(we_cnt), 32'd2);
        check("wr_oe_cycles", 32'(oe_cnt), 32'd2);

        // Simultaneous data read and fetch served back to back.
        @(posedge clock);
        #1;
        m_mem = 32'h55667788;
        m_if = 32'h01020304;
        push(3, 5);
        mem_mc_en = 1'b1;
        mem_mc_rw = 1'b0;
        mem_mc_addr = 18'h00020;
        if_mc_en = 1'b1;
        if_mc_addr = 18'h00000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            if (i == 0) begin
                mem_mc_en = 1'b0;
                if_mc_en = 1'b0;
            end
            @(negedge clock);
            check($sformatf("dual_addr%0d", i), {14'd0, sram_addr}, {14'd0, exp_a[i]});
            check($sformatf("dual_oe_n%0d", i), {31'd0, sram_oe_n}, 32'd0);
        end
        repeat (3) @(posedge clock);

        // Low address bits are ignored.
        m_if = 32'h1234ABCD;
        push(4, 3);
        issue(1'b1, 18'h00403, 1'b0, 1'b0, 18'd0, 32'd0, 4'hF, 1);
        repeat (3) @(posedge clock);

        // Write at byte address 0x18 -> halfwords 0x0C/0x0D, lane behaviour per build.
        push(5, 3);
        issue(1'b0, 18'd0, 1'b1, 1'b1, 18'h00018, 32'h11223344, 4'b0101, 1);
        @(negedge clock);
`ifdef MC_BYTE_WRITE_EN
        check("be_hi_lanes", {30'd0, sram_ub_n, sram_lb_n}, 32'b10);
`else
        check("be_hi_lanes", {30'd0, sram_ub_n, sram_lb_n}, 32'b00);
`endif
        @(posedge clock);
        @(negedge clock);
`ifdef MC_BYTE_WRITE_EN
        check("be_lo_lanes", {30'd0, sram_ub_n, sram_lb_n}, 32'b10);
`else
        check("be_lo_lanes", {30'd0, sram_ub_n, sram_lb_n}, 32'b00);
`endif
        repeat (2) @(posedge clock);
        #1;
`ifdef MC_BYTE_WRITE_EN
        check("be_hi_word", {16'd0, sram_mem[18'h00C]}, 32'h0000FF22);
        check("be_lo_word", {16'd0, sram_mem[18'h00D]}, 32'h0000FF44);
`else
        check("be_hi_word", {16'd0, sram_mem[18'h00C]}, 32'h00001122);
        check("be_lo_word", {16'd0, sram_mem[18'h00D]}, 32'h00003344);
`endif

        // Reset lands in D_LO of a write.
        issue(1'b0, 18'd0, 1'b1, 1'b1, 18'h00030, 32'hCAFEF00D, 4'hF, 1);
        @(posedge clock);
        #1;
        check("pre_rst_we_n", {31'd0, sram_we_n}, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        check("arst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("arst_data_oe", {31'd0, sram_data_oe}, 32'd0);
        check("arst_stall", {31'd0, mc_stall}, 32'd0);
        check("arst_if_data", mc_if_data, 32'd0);
        check("arst_mem_data", mc_mem_data, 32'd0);
        check("arst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        m_if = 32'd0;
        m_mem = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Normal operation resumes after reset.
        m_if = 32'h1234ABCD;
        push(6, 3);
        issue(1'b1, 18'h00400, 1'b0, 1'b0, 18'd0, 32'd0, 4'hF, 1);
        repeat (3) @(posedge clock);

        m_mem = 32'hDEADBEEF;
        push(7, 3);
        issue(1'b0, 18'd0, 1'b1, 1'b0, 18'h00010, 32'd0, 4'hF, 1);
        repeat (3) @(posedge clock);

        // A request held through DONE starts a second access.
        m_if = 32'h01020304;
        push(8, 3);
        push(9, 3);
        issue(1'b1, 18'h00000, 1'b0, 1'b0, 18'd0, 32'd0, 4'hF, 5);
        repeat (4) @(posedge clock);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
